// File: rtl/circuit_sequencer.sv
// Quantum circuit sequencer: walks a gate memory and feeds an external
// state-vector multiplier one gate at a time, capturing each result.
module circuit_sequencer #(
    parameter int SIZE         = 8,
    parameter int N            = 3,
    parameter int MAX_GATES    = 16,
    parameter int MULT_LATENCY = 1,
    localparam int DIM = 2 ** N,
    localparam int AW  = (MAX_GATES > 1) ? $clog2(MAX_GATES) : 1,
    localparam int CW  = AW + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [CW-1:0]             num_gates,
    input  logic [DIM-1:0][SIZE-1:0]  init_state,
    output logic [AW-1:0]             gate_addr,
    output logic [DIM-1:0][SIZE-1:0]  mult_state,
    input  logic [DIM-1:0][SIZE-1:0]  mult_result,
    input  logic                      mult_ovf,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output logic [CW-1:0]             gate_count,
    output logic                      ovf_err
);

    localparam int SW = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SETTLE,
        CAPTURE,
        DONE
    } state_t;

    state_t                   state;
    logic [DIM-1:0][SIZE-1:0] vec;
    logic [CW-1:0]            glim;
    logic [CW-1:0]            gsel;
    logic [SW-1:0]            scnt;
    logic                     last;
    logic                     running;

    assign gsel = (num_gates > CW'(MAX_GATES)) ? CW'(MAX_GATES) : num_gates;
    assign last = ({1'b0, gate_addr} == (glim - CW'(1)));
    assign running = (state == FETCH) || (state == SETTLE) || (state == CAPTURE);
    assign mult_state = vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            vec        <= '0;
            gate_addr  <= '0;
            gate_count <= '0;
            glim       <= '0;
            scnt       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            if (abort && running) begin
                // Abort drops the in-flight gate; vec keeps the last capture.
                state   <= IDLE;
                busy    <= 1'b0;
                aborted <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            vec        <= init_state;
                            gate_addr  <= '0;
                            gate_count <= '0;
                            ovf_err    <= 1'b0;
                            glim       <= gsel;
                            busy       <= 1'b1;
                            if (gsel == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= FETCH;
                            end
                        end
                    end
                    FETCH: begin
                        state <= SETTLE;
                        scnt  <= '0;
                    end
                    SETTLE: begin
                        if (scnt == SW'(MULT_LATENCY - 1)) begin
                            state <= CAPTURE;
                        end else begin
                            scnt <= scnt + SW'(1);
                        end
                    end
                    CAPTURE: begin
                        vec        <= mult_result;
                        gate_count <= gate_count + CW'(1);
                        ovf_err    <= ovf_err | mult_ovf;
                        if (last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            gate_addr <= gate_addr + AW'(1);
                            state     <= FETCH;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_circuit_sequencer.sv
// Bench for circuit_sequencer: permutation-gate multiplier model,
// directed corner runs plus randomized runs against a reference model.
module tb_circuit_sequencer;

    localparam int SIZE = 8;
    localparam int N    = 3;
    localparam int DIM  = 8;
    localparam int MAXG = 16;
    localparam int L    = 1;
    localparam int P    = L + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [4:0]  num_gates;
    logic [63:0] init_state;
    logic [3:0]  gate_addr;
    logic [63:0] mult_state;
    logic [63:0] mult_result;
    logic        mult_ovf;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [4:0]  gate_count;
    logic        ovf_err;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  gmem [0:15];
    logic [3:0]  gate_q;
    logic [63:0] res_q;

    circuit_sequencer #(
        .SIZE(SIZE),
        .N(N),
        .MAX_GATES(MAXG),
        .MULT_LATENCY(L)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .num_gates(num_gates),
        .init_state(init_state),
        .gate_addr(gate_addr),
        .mult_state(mult_state),
        .mult_result(mult_result),
        .mult_ovf(mult_ovf),
        .busy(busy),
        .done(done),
        .aborted(aborted),
        .gate_count(gate_count),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    // Gate code 0 is identity, code c>0 is Pauli-X on qubit c-1.
    function automatic logic [63:0] apply(input logic [3:0] code, input logic [63:0] v);
        logic [63:0] r;
        int m;
        m = (code == 4'd0) ? 0 : (1 << (int'(code) - 1));
        for (int i = 0; i < DIM; i++) r[SIZE*i +: SIZE] = v[SIZE*(i ^ m) +: SIZE];
        return r;
    endfunction

    // Synchronous-read gate memory feeding a one-cycle multiplier.
    always @(posedge clk) begin
        gate_q <= gmem[gate_addr];
        res_q  <= apply(gate_q, mult_state);
    end
    assign mult_result = res_q;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input int ng, input logic [63:0] init,
                       input logic [255:0] ovfv, input int abort_cyc,
                       input int bstart_cyc, input bit randg);
        int g, ncap, mask, exp_end, end_cyc, maxa, cyc, exp_maxa;
        bit is_abort, seen, got_done, got_abort;
        logic [63:0] expv;
        logic eovf;
        if (randg) for (int i = 0; i < 16; i++) gmem[i] = 4'($urandom_range(0, 3));
        g = (ng > MAXG) ? MAXG : ng;
        is_abort = (abort_cyc >= 1) && (abort_cyc <= P * g);
        ncap = 0;
        for (int k = 0; k < g; k++) if (!is_abort || (P * k + P < abort_cyc)) ncap++;
        mask = 0;
        eovf = 1'b0;
        for (int k = 0; k < ncap; k++) begin
            if (gmem[k] != 4'd0) mask ^= 1 << (int'(gmem[k]) - 1);
            eovf |= ovfv[P * k + P];
        end
        for (int i = 0; i < DIM; i++) expv[SIZE*i +: SIZE] = init[SIZE*(i ^ mask) +: SIZE];
        exp_end  = is_abort ? abort_cyc + 1 : P * g + 1;
        exp_maxa = is_abort ? (abort_cyc - 1) / P : ((g > 0) ? g - 1 : 0);

        start = 1'b1;
        num_gates = 5'(ng);
        init_state = init;
        @(posedge clk); #1;
        start = 1'b0;
        num_gates = 5'($urandom);
        init_state = {$urandom, $urandom};
        cyc = 1;
        seen = 0;
        maxa = 0;
        end_cyc = 0;
        got_done = 0;
        got_abort = 0;
        while (!seen && cyc <= 300) begin
            mult_ovf = (cyc < 256) ? ovfv[cyc] : 1'b0;
            abort = (cyc == abort_cyc);
            start = (cyc == bstart_cyc);
            if (start) num_gates = 5'd0;
            if (int'(gate_addr) > maxa) maxa = int'(gate_addr);
            if (done || aborted) begin
                seen = 1;
                end_cyc = cyc;
                got_done = done;
                got_abort = aborted;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check({tag, "_seen"}, 64'(seen), 64'(1));
        check({tag, "_cycle"}, 64'(end_cyc), 64'(exp_end));
        check({tag, "_done"}, 64'(got_done), 64'(!is_abort));
        check({tag, "_aborted"}, 64'(got_abort), 64'(is_abort));
        check({tag, "_state"}, mult_state, expv);
        check({tag, "_count"}, 64'(gate_count), 64'(ncap));
        check({tag, "_ovf"}, 64'(ovf_err), 64'(eovf));
        check({tag, "_busy"}, 64'(busy), 64'(!is_abort));
        check({tag, "_maxaddr"}, 64'(maxa), 64'(exp_maxa));
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        mult_ovf = 1'b0;
        check({tag, "_pulse"}, 64'({done, aborted, busy}), 64'(0));
        check({tag, "_hold"}, mult_state, expv);
        check({tag, "_holdcnt"}, 64'(gate_count), 64'(ncap));
    endtask

    initial begin
        int ng, g, ac, bs;
        logic [63:0] iv;
        logic [255:0] ov;
        for (int i = 0; i < 16; i++) gmem[i] = 4'd0;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mult_ovf = 1'b0;
        num_gates = 5'd0;
        init_state = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_flags", 64'({done, aborted, ovf_err}), 64'(0));
        check("rst_addr", 64'(gate_addr), 64'(0));
        check("rst_count", 64'(gate_count), 64'(0));
        check("rst_state", mult_state, 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        run("ident3", 3, 64'h40, '0, 0, 0, 0);
        gmem[0] = 4'd1;
        run("paulix", 1, 64'h40, '0, 0, 0, 0);
        run("zero", 0, 64'h0123_4567_89ab_cdef, '0, 0, 0, 1);
        run("clamp", 20, 64'h1122_3344_5566_7788, '0, 0, 0, 1);
        run("abort", 4, 64'h0807_0605_0403_0201, '0, P + 2, 2, 1);
        run("ovf_cap", 3, 64'h40, 256'(1) << (P + P), 0, 0, 1);
        ov = ~((256'(1) << P) | (256'(1) << (2 * P)) | (256'(1) << (3 * P)));
        run("ovf_out", 3, 64'h40, ov, 0, 0, 1);
        run("abort_done", 2, 64'h55aa_1234_0f0f_9876, '0, 2 * P + 1, 0, 1);
        run("abort_cap", 3, 64'hfedc_ba98_7654_3210, {8{32'hffff_ffff}}, 2 * P, 0, 1);

        for (int r = 0; r < 8; r++) begin
            ng = $urandom_range(0, 20);
            g = (ng > MAXG) ? MAXG : ng;
            iv = {$urandom, $urandom};
            ov = {8{$urandom}};
            ac = 0;
            bs = 0;
            if (g > 0) begin
                if ($urandom_range(0, 1) == 1) ac = $urandom_range(1, P * g);
                bs = $urandom_range(1, (ac > 0) ? ac : P * g);
            end
            run($sformatf("rnd%0d", r), ng, iv, ov, ac, bs, 1);
        end

        start = 1'b1;
        num_gates = 5'd4;
        init_state = 64'h0102_0304_0506_0708;
        mult_ovf = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (P + 1) @(posedge clk);
        #1;
        check("mid_busy", 64'(busy), 64'(1));
        check("mid_count", 64'(gate_count), 64'(1));
        check("mid_ovf", 64'(ovf_err), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mult_ovf = 1'b0;
        check("mrst_busy", 64'(busy), 64'(0));
        check("mrst_flags", 64'({done, aborted, ovf_err}), 64'(0));
        check("mrst_addr", 64'(gate_addr), 64'(0));
        check("mrst_count", 64'(gate_count), 64'(0));
        check("mrst_state", mult_state, 64'(0));

        reset = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        num_gates = 5'd2;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        check("rst_prio", 64'(busy), 64'(0));

        run("after_rst", 5, 64'h40, {8{$urandom}}, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
